// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports and the shared memory port of mem_arbiter.
// The slave modport is the arbiter's view; master is the requesters/memory side.
interface mem_arbiter_if #(
  parameter int unsigned XLEN = 32
);
  localparam int unsigned MASK_W = 4;

  logic [XLEN-1:0]   m0_addr;
  logic [XLEN-1:0]   m1_addr;
  logic [XLEN-1:0]   m0_wdata;
  logic [XLEN-1:0]   m1_wdata;
  logic [MASK_W-1:0] m0_wmask;
  logic [MASK_W-1:0] m1_wmask;
  logic              m0_rstrb;
  logic              m1_rstrb;
  logic              m0_lock;
  logic              m1_lock;
  logic              m0_ack;
  logic              m1_ack;
  logic [XLEN-1:0]   m0_rdata;
  logic [XLEN-1:0]   m1_rdata;
  logic              m0_rvalid;
  logic              m1_rvalid;

  logic [XLEN-1:0]   mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [MASK_W-1:0] mem_wmask;
  logic              mem_rstrb;
  logic [XLEN-1:0]   mem_rdata;

  modport slave (
    input  m0_addr, m1_addr, m0_wdata, m1_wdata, m0_wmask, m1_wmask,
    input  m0_rstrb, m1_rstrb, m0_lock, m1_lock, mem_rdata,
    output m0_ack, m1_ack, m0_rdata, m1_rdata, m0_rvalid, m1_rvalid,
    output mem_addr, mem_wdata, mem_wmask, mem_rstrb
  );

  modport master (
    output m0_addr, m1_addr, m0_wdata, m1_wdata, m0_wmask, m1_wmask,
    output m0_rstrb, m1_rstrb, m0_lock, m1_lock, mem_rdata,
    input  m0_ack, m1_ack, m0_rdata, m1_rdata, m0_rvalid, m1_rvalid,
    input  mem_addr, mem_wdata, mem_wmask, mem_rstrb
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter onto a single memory port with a 1-cycle read latency.
// Optional grant locking is compiled in with MEM_ARBITER_LOCK_EN (pure round-robin otherwise).
module mem_arbiter #(
  parameter int unsigned XLEN = 32
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);
  localparam int unsigned MASK_W = 4;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_LOCK0 = 2'd1,
    ARB_LOCK1 = 2'd2
  } arb_state_e;

  arb_state_e        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_owner_q, rd_owner_d;

  logic              req0_c, req1_c;
  logic              gnt0_c, gnt1_c;
  logic [XLEN-1:0]   addr_c;
  logic [XLEN-1:0]   wdata_c;
  logic [MASK_W-1:0] wmask_c;
  logic              rstrb_c;

  // State register: lock FSM, round-robin pointer and read owner tag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= 1'b1;
      rd_valid_q   <= 1'b0;
      rd_owner_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rd_valid_q   <= rd_valid_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

  // Grant selection, bookkeeping and next state.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    rd_valid_d   = 1'b0;
    rd_owner_d   = rd_owner_q;
    gnt0_c       = 1'b0;
    gnt1_c       = 1'b0;

    req0_c = bus.m0_rstrb | (bus.m0_wmask != MASK_W'(0));
    req1_c = bus.m1_rstrb | (bus.m1_wmask != MASK_W'(0));

    if (!reset) begin
      case (state_q)
        ARB_LOCK0: gnt0_c = req0_c;
        ARB_LOCK1: gnt1_c = req1_c;
        default: begin
          // On conflict the requester that was not granted last wins.
          if (req0_c && req1_c) begin
            gnt0_c = last_grant_q;
            gnt1_c = ~last_grant_q;
          end else begin
            gnt0_c = req0_c;
            gnt1_c = req1_c;
          end
        end
      endcase
    end

    if (gnt0_c) begin
      last_grant_d = 1'b0;
      rd_valid_d   = bus.m0_rstrb;
      rd_owner_d   = 1'b0;
    end else if (gnt1_c) begin
      last_grant_d = 1'b1;
      rd_valid_d   = bus.m1_rstrb;
      rd_owner_d   = 1'b1;
    end

`ifdef MEM_ARBITER_LOCK_EN
    case (state_q)
      ARB_IDLE: begin
        if (gnt0_c && bus.m0_lock) begin
          state_d = ARB_LOCK0;
        end else if (gnt1_c && bus.m1_lock) begin
          state_d = ARB_LOCK1;
        end
      end
      ARB_LOCK0: if (gnt0_c && !bus.m0_lock) state_d = ARB_IDLE;
      ARB_LOCK1: if (gnt1_c && !bus.m1_lock) state_d = ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase
`else
    state_d = ARB_IDLE;
`endif
  end

`ifndef MEM_ARBITER_LOCK_EN
  logic unused_lock;
  assign unused_lock = bus.m0_lock ^ bus.m1_lock;
`endif

  // Forward the granted request; drive zeros when nobody is granted.
  always_comb begin
    addr_c  = '0;
    wdata_c = '0;
    wmask_c = '0;
    rstrb_c = 1'b0;
    if (gnt0_c) begin
      addr_c  = bus.m0_addr;
      wdata_c = bus.m0_wdata;
      wmask_c = bus.m0_wmask;
      rstrb_c = bus.m0_rstrb;
    end else if (gnt1_c) begin
      addr_c  = bus.m1_addr;
      wdata_c = bus.m1_wdata;
      wmask_c = bus.m1_wmask;
      rstrb_c = bus.m1_rstrb;
    end
  end

  assign bus.mem_addr  = addr_c;
  assign bus.mem_wdata = wdata_c;
  assign bus.mem_wmask = wmask_c;
  assign bus.mem_rstrb = rstrb_c;

  assign bus.m0_ack = gnt0_c;
  assign bus.m1_ack = gnt1_c;

  // Read data is broadcast; rvalid is qualified by the owner tag and masked in reset.
  assign bus.m0_rdata  = bus.mem_rdata;
  assign bus.m1_rdata  = bus.mem_rdata;
  assign bus.m0_rvalid = ~reset & rd_valid_q & ~rd_owner_q;
  assign bus.m1_rvalid = ~reset & rd_valid_q &  rd_owner_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle reference model plus literal expectations.
// Works with MEM_ARBITER_LOCK_EN either defined or undefined.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  mem_arbiter_if #(.XLEN(32)) bus ();

  mem_arbiter #(.XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic rs, input logic [3:0] wm, input logic [31:0] a,
                      input logic [31:0] wd, input logic lk);
    bus.m0_rstrb = rs; bus.m0_wmask = wm; bus.m0_addr = a; bus.m0_wdata = wd; bus.m0_lock = lk;
  endtask

  task automatic set1(input logic rs, input logic [3:0] wm, input logic [31:0] a,
                      input logic [31:0] wd, input logic lk);
    bus.m1_rstrb = rs; bus.m1_wmask = wm; bus.m1_addr = a; bus.m1_wdata = wd; bus.m1_lock = lk;
  endtask

  task automatic idle_all();
    set0(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    set1(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
  endtask

  // Reference model: who wins, which read is outstanding, who holds a lock.
  int last_win = 1;
  int lock_own = -1;
  int pend     = -1;

  always @(negedge clk) begin
    int          win;
    bit          r0, r1;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_wmask;
    logic        e_rstrb, w_rstrb, w_lock;

    r0  = bus.m0_rstrb || (bus.m0_wmask != 4'h0);
    r1  = bus.m1_rstrb || (bus.m1_wmask != 4'h0);
    win = -1;
    if (!reset) begin
      if (lock_own == 0)      win = r0 ? 0 : -1;
      else if (lock_own == 1) win = r1 ? 1 : -1;
      else if (r0 && r1)      win = (last_win == 0) ? 1 : 0;
      else if (r0)            win = 0;
      else if (r1)            win = 1;
    end

    e_addr = 32'h0; e_wdata = 32'h0; e_wmask = 4'h0; e_rstrb = 1'b0; w_lock = 1'b0;
    if (win == 0) begin
      e_addr = bus.m0_addr; e_wdata = bus.m0_wdata; e_wmask = bus.m0_wmask;
      e_rstrb = bus.m0_rstrb; w_lock = bus.m0_lock;
    end else if (win == 1) begin
      e_addr = bus.m1_addr; e_wdata = bus.m1_wdata; e_wmask = bus.m1_wmask;
      e_rstrb = bus.m1_rstrb; w_lock = bus.m1_lock;
    end
    w_rstrb = e_rstrb;

    chk("m0_ack",    32'(bus.m0_ack),    32'(win == 0));
    chk("m1_ack",    32'(bus.m1_ack),    32'(win == 1));
    chk("mem_addr",  bus.mem_addr,       e_addr);
    chk("mem_wdata", bus.mem_wdata,      e_wdata);
    chk("mem_wmask", 32'(bus.mem_wmask), 32'(e_wmask));
    chk("mem_rstrb", 32'(bus.mem_rstrb), 32'(e_rstrb));
    chk("m0_rvalid", 32'(bus.m0_rvalid), 32'(!reset && pend == 0));
    chk("m1_rvalid", 32'(bus.m1_rvalid), 32'(!reset && pend == 1));
    chk("m0_rdata",  bus.m0_rdata,       bus.mem_rdata);
    chk("m1_rdata",  bus.m1_rdata,       bus.mem_rdata);

    if (reset) begin
      last_win = 1; lock_own = -1; pend = -1;
    end else begin
      pend = (win >= 0 && w_rstrb) ? win : -1;
      if (win >= 0) last_win = win;
`ifdef MEM_ARBITER_LOCK_EN
      if (win >= 0) begin
        if (lock_own < 0 && w_lock)              lock_own = win;
        else if (lock_own == win && !w_lock)     lock_own = -1;
      end
`else
      if (w_lock) lock_own = -1;
`endif
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, got stuck, expected completion");
    $fatal(1);
  end

  initial begin
    logic [5:0] a0, a1;
    int k;

    reset = 1'b1;
    idle_all();
    bus.mem_rdata = 32'h0;
    step();

    // Requests during reset are not forwarded
    set0(1'b1, 4'h0, 32'h10, 32'h0, 1'b0);
    @(negedge clk);
    chk("rst_m0_ack",    32'(bus.m0_ack),    32'h0);
    chk("rst_mem_rstrb", 32'(bus.mem_rstrb), 32'h0);
    chk("rst_mem_addr",  bus.mem_addr,       32'h0);

    // Sole m0 read of 0x10
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("read_m0_ack",  32'(bus.m0_ack), 32'h1);
    chk("read_addr",    bus.mem_addr,    32'h10);
    step();
    idle_all();
    bus.mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("read_m0_rvalid", 32'(bus.m0_rvalid), 32'h1);
    chk("read_m0_rdata",  bus.m0_rdata,       32'hDEADBEEF);
    chk("read_m1_rvalid", 32'(bus.m1_rvalid), 32'h0);

    // Conflict right after reset: m0 first, then m1's write
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    set0(1'b1, 4'h0, 32'h0, 32'h0, 1'b0);
    set1(1'b0, 4'hF, 32'h20, 32'hCAFEF00D, 1'b0);
    @(negedge clk);
    chk("conf_m0_ack", 32'(bus.m0_ack), 32'h1);
    chk("conf_m1_ack", 32'(bus.m1_ack), 32'h0);
    step();
    set0(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk("conf_m1_ack",    32'(bus.m1_ack),    32'h1);
    chk("conf_wdata",     bus.mem_wdata,      32'hCAFEF00D);
    chk("conf_m0_rvalid", 32'(bus.m0_rvalid), 32'h1);

    // Sustained contention for 6 cycles
    step();
    set0(1'b1, 4'h0, 32'h100, 32'h0, 1'b0);
    set1(1'b1, 4'h0, 32'h200, 32'h0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      bus.mem_rdata = 32'h1000_0000 + 32'(i);
      @(negedge clk);
      a0[i] = bus.m0_ack;
      a1[i] = bus.m1_ack;
      chk("rr_m0_rvalid", 32'(bus.m0_rvalid), 32'(i % 2));
      step();
    end
    chk("rr_m0_seq", 32'(a0), 32'h15);
    chk("rr_m1_seq", 32'(a1), 32'h2A);
    idle_all();

    // Sole m0 transfer so that m1 wins the next conflict
    step();
    set0(1'b1, 4'h0, 32'h300, 32'h0, 1'b0);
    @(negedge clk);
    chk("pre_m0_ack", 32'(bus.m0_ack), 32'h1);

    // m1 issues lock=1,1,0 while m0 writes continuously
    step();
    set0(1'b0, 4'h3, 32'h400, 32'h55, 1'b0);
    k = 0;
    for (int c = 0; c < 6; c++) begin
      if (k < 3) set1(1'b1, 4'hF, 32'h500 + 32'(4 * k), 32'hA0 + 32'(k), k < 2);
      else       set1(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      a0[c] = bus.m0_ack;
      a1[c] = bus.m1_ack;
      if (bus.m1_ack) k++;
      step();
    end
`ifdef MEM_ARBITER_LOCK_EN
    chk("lock_m0_seq", 32'(a0), 32'h38);
    chk("lock_m1_seq", 32'(a1), 32'h07);
`else
    chk("nolock_m0_seq", 32'(a0), 32'h2A);
    chk("nolock_m1_seq", 32'(a1), 32'h15);
`endif
    chk("lock_m1_done", 32'(k), 32'h3);

    // m1 read (with lock) acked, then reset the next cycle
    idle_all();
    step();
    set1(1'b1, 4'h0, 32'h600, 32'h0, 1'b1);
    @(negedge clk);
    chk("rstrd_m1_ack", 32'(bus.m1_ack), 32'h1);
    step();
    reset = 1'b1;
    set0(1'b1, 4'h0, 32'h700, 32'h0, 1'b0);
    set1(1'b1, 4'h0, 32'h800, 32'h0, 1'b0);
    @(negedge clk);
    chk("rstrd_m1_rvalid", 32'(bus.m1_rvalid), 32'h0);
    chk("rstrd_mem_addr",  bus.mem_addr,       32'h0);
    chk("rstrd_mem_rstrb", 32'(bus.mem_rstrb), 32'h0);
    chk("rstrd_m1_ack",    32'(bus.m1_ack),    32'h0);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("post_m0_ack",    32'(bus.m0_ack),    32'h1);
    chk("post_m1_ack",    32'(bus.m1_ack),    32'h0);
    chk("post_m1_rvalid", 32'(bus.m1_rvalid), 32'h0);
    step();
    idle_all();
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter: XLEN, 32, data and address width.
REQ-002 SHALL have port: clk  input  1  rising-edge clock, sole clock.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports: m0_addr / m1_addr  input  XLEN  requester byte address.
REQ-005 SHALL have ports: m0_wdata / m1_wdata  input  XLEN  store data, lanes pre-replicated by requester.
REQ-006 SHALL have ports: m0_wmask / m1_wmask  input  4  byte write enables.
REQ-007 SHALL have ports: m0_rstrb / m1_rstrb  input  1  read request.
REQ-008 SHALL have ports: m0_lock / m1_lock  input  1  hold grant after this transfer.
REQ-009 SHALL have ports: m0_ack / m1_ack  output  1  request forwarded this cycle.
REQ-010 SHALL have ports: m0_rdata / m1_rdata  output  XLEN  read data, a copy of mem_rdata.
REQ-011 SHALL have ports: m0_rvalid / m1_rvalid  output  1  rdata valid for this requester.
REQ-012 SHALL have ports: mem_addr / mem_wdata  output  XLEN, mem_wmask  output  4, mem_rstrb  output  1, mem_rdata  input  XLEN  shared memory port, 1-cycle read latency.

Function
REQ-013 SHALL treat mX as requesting when mX_rstrb=1 or mX_wmask!=0.
REQ-014 SHALL forward at most one requester per cycle, combinationally.
- mem_* SHALL carry the granted requester's addr, wdata, wmask and rstrb.
- mX_ack SHALL be high in that same cycle.
- mem_* SHALL be all zero when nothing is granted.
REQ-015 SHALL forward rstrb and wmask asserted together as a single transfer.
REQ-016 A requester SHALL hold its request stable until it sees ack; the arbiter keeps no request buffer.
REQ-017 SHALL grant a sole requester immediately, in the same cycle, with zero added latency.
REQ-018 SHALL grant round-robin when both request.
- The requester not granted last SHALL win.
- The last_grant register SHALL update on every acked transfer.
REQ-019 SHALL register the read owner tag on each acked read.
- mX_rvalid SHALL pulse exactly one cycle later, for the owner only.
- mX_rdata SHALL equal mem_rdata.
- Back-to-back reads from alternating requesters SHALL each get a correct rvalid.
REQ-020 SHALL keep a 3-state FSM: ARB_IDLE, ARB_LOCK0, ARB_LOCK1.
- ARB_IDLE SHALL use round-robin (REQ-018).
- ARB_LOCKx SHALL grant only mx; the other requester stalls with ack=0.
REQ-021 SHALL make these FSM transitions:
- From ARB_IDLE, an acked mX transfer with mX_lock=1 SHALL go to ARB_LOCKX.
- From ARB_LOCKX, an acked mX transfer with mX_lock=0 SHALL go to ARB_IDLE.
- Otherwise the FSM SHALL hold its state.
REQ-022 SHALL keep last_grant=X when leaving ARB_LOCKX, so the other requester wins the next conflict.

Reset
REQ-023 SHALL set, on reset:
- FSM to ARB_IDLE.
- last_grant to 1, so m0 wins the first conflict.
- Read owner tag to invalid.
REQ-024 While reset=1, all ack, rvalid and mem_* outputs SHALL be 0.
- mX_rdata SHALL still follow mem_rdata.
REQ-025 SHALL drop a read acked in the cycle before reset asserts; no rvalid follows.
REQ-026 SHALL start from idle on the first cycle after reset deasserts, with no residual lock or pending rvalid.

Configuration
REQ-027 SHALL gate the lock feature with macro MEM_ARBITER_LOCK_EN.
- When defined, REQ-020..022 SHALL apply.
- When undefined, m0_lock and m1_lock SHALL remain as ports but be ignored, and the FSM SHALL stay in ARB_IDLE.
- Undefined behaviour is pure round-robin.

Verification
REQ-028 SHALL cover a sole m0 read:
- Stimulus: m0 reads addr 0x10, memory returns 0xDEADBEEF.
- Response: m0_ack same cycle; next cycle m0_rvalid=1, m0_rdata=0xDEADBEEF, m1_rvalid=0.
REQ-029 SHALL cover a conflict after reset:
- Stimulus: m0 reads 0x0 and m1 writes 0x20 with wmask 4'b1111 in the same cycle.
- Response: m0 acked first, then m1 in the next cycle, mem_wdata equal to m1_wdata.
REQ-030 SHALL cover sustained contention:
- Stimulus: both request continuously for 6 cycles.
- Response: grants alternate m0,m1,m0,m1,m0,m1; each read's rvalid goes only to its owner.
REQ-031 SHALL cover lock (MEM_ARBITER_LOCK_EN defined):
- Stimulus: m1 issues 3 transfers with lock=1,1,0 while m0 requests continuously.
- Response: m0_ack=0 throughout, then m0 is granted on the cycle after m1's unlocking transfer.
REQ-032 SHALL cover lock compiled out (MEM_ARBITER_LOCK_EN undefined):
- Stimulus: same as REQ-031.
- Response: m0 and m1 alternate.
REQ-033 SHALL cover reset mid-read:
- Stimulus: m1 read acked, reset asserted the next cycle.
- Response: m1_rvalid stays 0, all mem_* are 0, and the first conflict after reset goes to m0.
